// File: rtl/sopc_timer_pkg.sv
// Shared definitions for the SOPC interval timer: register offsets,
// status/control bit positions and the address decode classification.
package sopc_timer_pkg;

   // Word offsets of the fixed registers
   localparam int unsigned REG_STATUS      = 0;
   localparam int unsigned REG_CONTROL     = 1;
   localparam int unsigned REG_PRESCALE    = 2;
   localparam int unsigned REG_PERIOD_BASE = 3;

   // STATUS bit positions
   localparam int unsigned STATUS_TO  = 0;
   localparam int unsigned STATUS_RUN = 1;

   // CONTROL bit positions (START/STOP are write-only strobes)
   localparam int unsigned CTRL_ITO   = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_START = 2;
   localparam int unsigned CTRL_STOP  = 3;

   // Which register a word address selects
   typedef enum logic [2:0] {
      REG_KIND_STATUS,
      REG_KIND_CONTROL,
      REG_KIND_PRESCALE,
      REG_KIND_PERIOD,
      REG_KIND_SNAP,
      REG_KIND_NONE
   } reg_kind_e;

   // SNAP words follow the N PERIOD words
   function automatic int unsigned snap_base(input int unsigned n);
      return REG_PERIOD_BASE + n;
   endfunction

endpackage

// File: rtl/sopc_interval_timer_gen2_if.sv
// Avalon-MM slave bus bundle for the interval timer.
interface sopc_interval_timer_gen2_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] address;
   logic                  chipselect;
   logic                  write_n;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/sopc_timer_prescaler.sv
// Prescaler: counts 0..prescale while running and flags the last count.
module sopc_timer_prescaler #(
   parameter int unsigned PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      run,
   input  logic                      clear,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick
);

   logic [PRESCALE_WIDTH-1:0] count;

   // Tick on the final prescale count, only while running
   always_comb begin
      tick = run && (count == prescale);
   end

   // Prescale counter: clear wins, otherwise wrap after the tick
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         if (tick) count <= '0;
         else      count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sopc_interval_timer_gen2.sv
// Avalon-MM interval timer: prescaled down-counter with one-shot and
// continuous modes, full-width snapshot, masked irq and timeout pulse.
module sopc_interval_timer_gen2
   import sopc_timer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned COUNT_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned PRESCALE_WIDTH = 8,
   parameter logic [COUNT_WIDTH-1:0] RESET_PERIOD = COUNT_WIDTH'(32'h7A11F)
) (
   input  logic clk,
   input  logic reset_n,
   sopc_interval_timer_gen2_if.slave bus,
   output logic irq,
   output logic timeout_pulse
);

   localparam int unsigned N         = COUNT_WIDTH / DATA_WIDTH;
   localparam int unsigned SNAP_BASE = snap_base(N);

   logic [31:0]               addr_u;
   reg_kind_e                 kind;
   int unsigned               word_idx;

   logic                      we;
   logic                      wr_status;
   logic                      wr_control;
   logic                      wr_prescale;
   logic                      wr_period;
   logic                      wr_snap;
   logic                      start;
   logic                      stop;
   logic                      tick;
   logic                      terminal;

   logic                      ito;
   logic                      cont;
   logic                      run;
   logic                      to_flag;
   logic                      force_reload;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [COUNT_WIDTH-1:0]    period;
   logic [COUNT_WIDTH-1:0]    counter;
   logic [COUNT_WIDTH-1:0]    snap;
   logic [DATA_WIDTH-1:0]     rd_mux;

   // Classify the word address and find the word within PERIOD/SNAP
   always_comb begin
      addr_u   = {{(32-ADDR_WIDTH){1'b0}}, bus.address};
      kind     = REG_KIND_NONE;
      word_idx = 0;
      if (addr_u == REG_STATUS) begin
         kind = REG_KIND_STATUS;
      end else if (addr_u == REG_CONTROL) begin
         kind = REG_KIND_CONTROL;
      end else if (addr_u == REG_PRESCALE) begin
         kind = REG_KIND_PRESCALE;
      end else if (addr_u >= REG_PERIOD_BASE && addr_u < SNAP_BASE) begin
         kind     = REG_KIND_PERIOD;
         word_idx = addr_u - REG_PERIOD_BASE;
      end else if (addr_u >= SNAP_BASE && addr_u < SNAP_BASE + N) begin
         kind     = REG_KIND_SNAP;
         word_idx = addr_u - SNAP_BASE;
      end
   end

   // Write strobes and the terminal-tick condition
   always_comb begin
      we          = bus.chipselect & ~bus.write_n;
      wr_status   = we && (kind == REG_KIND_STATUS);
      wr_control  = we && (kind == REG_KIND_CONTROL);
      wr_prescale = we && (kind == REG_KIND_PRESCALE);
      wr_period   = we && (kind == REG_KIND_PERIOD);
      wr_snap     = we && (kind == REG_KIND_SNAP);
      start       = wr_control && bus.writedata[CTRL_START];
      stop        = wr_control && bus.writedata[CTRL_STOP];
      // A pending reload suppresses the tick so no timeout is produced
      terminal    = tick && (counter == '0) && !force_reload;
   end

   sopc_timer_prescaler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .run      (run),
      .clear    (start | force_reload),
      .prescale (prescale),
      .tick     (tick)
   );

   // Software-visible configuration, snapshot and reload request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ito          <= 1'b0;
         cont         <= 1'b0;
         prescale     <= '0;
         period       <= RESET_PERIOD;
         snap         <= '0;
         force_reload <= 1'b0;
      end else begin
         force_reload <= wr_period;
         if (wr_control) begin
            ito  <= bus.writedata[CTRL_ITO];
            cont <= bus.writedata[CTRL_CONT];
         end
         if (wr_prescale) begin
            prescale <= bus.writedata[PRESCALE_WIDTH-1:0];
         end
         if (wr_period) begin
            for (int unsigned i = 0; i < N; i++) begin
               if (word_idx == i) period[i*DATA_WIDTH +: DATA_WIDTH] <= bus.writedata;
            end
         end
         if (wr_snap) begin
            snap <= counter;
         end
      end
   end

   // Down-counter, run state, timeout flag and pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter       <= RESET_PERIOD;
         run           <= 1'b0;
         to_flag       <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= terminal;

         if (force_reload) begin
            counter <= period;
         end else if (tick) begin
            if (counter == '0) counter <= period;
            else               counter <= counter - 1'b1;
         end

         // Reload beats START, START beats STOP
         if (force_reload)          run <= 1'b0;
         else if (start)            run <= 1'b1;
         else if (stop)             run <= 1'b0;
         else if (terminal && !cont) run <= 1'b0;

         // Setting on a terminal tick beats a clearing STATUS write
         if (terminal)       to_flag <= 1'b1;
         else if (wr_status) to_flag <= 1'b0;
      end
   end

   // Read mux, unconditionally decoded from the current address
   always_comb begin
      rd_mux = '0;
      case (kind)
         REG_KIND_STATUS: begin
            rd_mux[STATUS_TO]  = to_flag;
            rd_mux[STATUS_RUN] = run;
         end
         REG_KIND_CONTROL: begin
            rd_mux[CTRL_ITO]  = ito;
            rd_mux[CTRL_CONT] = cont;
         end
         REG_KIND_PRESCALE: begin
            rd_mux[PRESCALE_WIDTH-1:0] = prescale;
         end
         REG_KIND_PERIOD: begin
            for (int unsigned i = 0; i < N; i++) begin
               if (word_idx == i) rd_mux = period[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         REG_KIND_SNAP: begin
            for (int unsigned i = 0; i < N; i++) begin
               if (word_idx == i) rd_mux = snap[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         default: rd_mux = '0;
      endcase
   end

   // Registered read data, one cycle behind the address
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.readdata <= '0;
      else          bus.readdata <= rd_mux;
   end

   // Interrupt is the timeout flag masked by ITO
   always_comb begin
      irq = to_flag & ito;
   end

endmodule

// File: tb/tb_sopc_interval_timer_gen2.sv
// Bench for sopc_interval_timer_gen2 with a 16-bit bus and 64-bit counter.
module tb_sopc_interval_timer_gen2;

   logic clk = 1'b0;
   logic reset_n;
   logic irq;
   logic timeout_pulse;

   int nvec = 0;
   int nerr = 0;

   sopc_interval_timer_gen2_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

   sopc_interval_timer_gen2 #(
      .DATA_WIDTH     (16),
      .COUNT_WIDTH    (64),
      .ADDR_WIDTH     (4),
      .PRESCALE_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .irq           (irq),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   // Abstract timer state: whole 64-bit values, word access by shifting
   typedef struct {
      longint unsigned period;
      longint unsigned cnt;
      longint unsigned snap;
      int unsigned     pre;
      int unsigned     pcnt;
      bit              run;
      bit              to_f;
      bit              ito;
      bit              cont;
      bit              reload;
      bit              pulse;
      logic [15:0]     rd;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.period = 64'h7A11F;
      r.cnt    = 64'h7A11F;
      r.snap   = 0;
      r.pre    = 0;
      r.pcnt   = 0;
      r.run    = 0;
      r.to_f   = 0;
      r.ito    = 0;
      r.cont   = 0;
      r.reload = 0;
      r.pulse  = 0;
      r.rd     = 16'h0;
      return r;
   endfunction

   function automatic logic [15:0] read_word(model_t s, int a);
      if (a == 0) return {14'b0, s.run, s.to_f};
      if (a == 1) return {14'b0, s.cont, s.ito};
      if (a == 2) return 16'(s.pre);
      if (a >= 3 && a <= 6) return 16'(s.period >> (16 * (a - 3)));
      if (a >= 7 && a <= 10) return 16'(s.snap >> (16 * (a - 7)));
      return 16'h0;
   endfunction

   function automatic model_t model_step(model_t s, bit we, int a, logic [15:0] wd);
      model_t n;
      bit start, stop, tick, term;
      n     = s;
      start = we && (a == 1) && wd[2];
      stop  = we && (a == 1) && wd[3];
      tick  = s.run && (s.pcnt == s.pre);
      term  = tick && (s.cnt == 0) && !s.reload;

      n.rd     = read_word(s, a);
      n.pulse  = term;
      n.reload = we && (a >= 3) && (a <= 6);
      if (we && a >= 3 && a <= 6)
         n.period = (s.period & ~(64'hFFFF << (16 * (a - 3)))) | ({48'b0, wd} << (16 * (a - 3)));
      if (we && a == 2) n.pre = int'(wd[7:0]);
      if (we && a == 1) begin
         n.ito  = wd[0];
         n.cont = wd[1];
      end
      if (we && a >= 7 && a <= 10) n.snap = s.cnt;

      if (s.reload)  n.cnt = s.period;
      else if (tick) n.cnt = (s.cnt == 0) ? s.period : s.cnt - 1;

      if (s.reload)              n.run = 0;
      else if (start)            n.run = 1;
      else if (stop)             n.run = 0;
      else if (term && !s.cont)  n.run = 0;

      if (s.reload || start) n.pcnt = 0;
      else if (s.run)        n.pcnt = tick ? 0 : s.pcnt + 1;

      if (term)                 n.to_f = 1;
      else if (we && a == 0)    n.to_f = 0;
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= model_reset();
      else m <= model_step(m, bus.chipselect & ~bus.write_n, int'(bus.address), bus.writedata);
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if ($time > 2) begin
         nvec++;
         if (bus.readdata !== m.rd || irq !== (m.to_f & m.ito) || timeout_pulse !== m.pulse) begin
            nerr++;
            $display("FAIL model t=%0t readdata=%h exp=%h irq=%b exp=%b pulse=%b exp=%b",
                     $time, bus.readdata, m.rd, irq, m.to_f & m.ito, timeout_pulse, m.pulse);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      bus.address    = 4'(a);
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      bus.writedata  = d;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic rd(input int a, output logic [15:0] d);
      bus.address    = 4'(a);
      bus.chipselect = 1'b1;
      @(posedge clk);
      #1;
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   task automatic set_period(input logic [63:0] p);
      logic [63:0] v;
      v = p;
      for (int w = 0; w < 4; w++) wr(3 + w, v[16*w +: 16]);
   endtask

   task automatic chk_snap(input string name, input logic [63:0] exp);
      logic [15:0] d;
      logic [63:0] got;
      got = '0;
      for (int w = 0; w < 4; w++) begin
         rd(7 + w, d);
         got[16*w +: 16] = d;
      end
      chk(name, got, exp);
   endtask

   initial begin
      logic [15:0] d;
      logic [15:0] rst_exp [12];
      rst_exp = '{16'h0, 16'h0, 16'h0, 16'hA11F, 16'h0007, 16'h0, 16'h0,
                  16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

      bus.address    = '0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state of every offset
      chk("reset irq", 64'(irq), 64'h0);
      chk("reset pulse", 64'(timeout_pulse), 64'h0);
      for (int a = 0; a < 12; a++) begin
         rd(a, d);
         chk($sformatf("reset rd[%0d]", a), 64'(d), 64'(rst_exp[a]));
      end

      // Continuous, PERIOD 4, PRESCALE 0: pulse every 5 clocks
      set_period(64'd4);
      wr(2, 16'h0000);
      wr(1, 16'h0007);
      for (int k = 1; k <= 15; k++) begin
         idle(1);
         chk($sformatf("cont pulse k=%0d", k), 64'(timeout_pulse), 64'((k % 5) == 0));
         if (k == 4) chk("irq before first timeout", 64'(irq), 64'h0);
         if (k == 5) chk("irq after first timeout", 64'(irq), 64'h1);
      end
      wr(0, 16'h0000);
      chk("irq cleared by STATUS write", 64'(irq), 64'h0);
      idle(3);
      chk("irq still low", 64'(irq), 64'h0);
      idle(1);
      chk("next pulse 5 clocks later", 64'(timeout_pulse), 64'h1);
      chk("irq re-asserted", 64'(irq), 64'h1);
      wr(1, 16'h0008);
      wr(0, 16'h0000);
      chk("irq after stop", 64'(irq), 64'h0);

      // One-shot, PERIOD 2, PRESCALE 3: single pulse 12 clocks after START
      set_period(64'd2);
      wr(2, 16'h0003);
      wr(1, 16'h0004);
      for (int k = 1; k <= 16; k++) begin
         idle(1);
         chk($sformatf("oneshot pulse k=%0d", k), 64'(timeout_pulse), 64'(k == 12));
      end
      rd(0, d);
      chk("oneshot STATUS", 64'(d), 64'h1);
      chk("oneshot irq masked", 64'(irq), 64'h0);

      // 64-bit borrow across words with snapshots
      wr(0, 16'h0000);
      set_period(64'h1_0000_0002);
      wr(2, 16'h0000);
      wr(1, 16'h0006);
      idle(2);
      wr(7, 16'h0000);
      chk_snap("snap at word boundary", 64'h1_0000_0000);
      wr(8, 16'h0000);
      chk_snap("snap after borrow", 64'h0000_0000_FFFF_FFFB);
      wr(3, 16'h0005);
      idle(1);
      rd(0, d);
      chk("PERIOD write stops RUN", 64'(d), 64'h0);
      wr(7, 16'h0000);
      chk_snap("snap after reload", 64'h1_0000_0005);

      // START in the cycle after a PERIOD write: reload wins
      set_period(64'd2);
      wr(1, 16'h0006);
      rd(0, d);
      chk("START vs reload", 64'(d), 64'h0);

      // STATUS write on the terminal tick keeps TO
      wr(1, 16'h0006);
      idle(2);
      wr(0, 16'h0000);
      chk("pulse on terminal cycle", 64'(timeout_pulse), 64'h1);
      rd(0, d);
      chk("TO survives STATUS write", 64'(d), 64'h3);

      // START|STOP together leaves RUN set
      wr(1, 16'h0008);
      wr(1, 16'h000C);
      rd(0, d);
      chk("START|STOP", 64'(d), 64'h3);

      // Asynchronous reset mid-count
      wr(1, 16'h0007);
      idle(3);
      chk("irq before reset", 64'(irq), 64'h1);
      rd(0, d);
      #2 reset_n = 1'b0;
      #1;
      chk("async reset readdata", 64'(bus.readdata), 64'h0);
      chk("async reset irq", 64'(irq), 64'h0);
      chk("async reset pulse", 64'(timeout_pulse), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      idle(3);
      chk("irq after release", 64'(irq), 64'h0);
      wr(7, 16'h0000);
      chk_snap("counter after reset", 64'h7A11F);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
